// File: rtl/decimador_qmn.sv
// ---------------------------------------------------------------------------
// decimador_qmn
//
// Integrate-and-dump decimator for two's complement Qm.n samples. Every M
// accepted samples are summed in a guard-bit accumulator. On the edge that
// accepts the M-th sample, the block emits their mean, rounded half toward
// +infinity, and starts a new group.
//
// Parameters
//   M  decimation factor, a power of two in 2..16 (K = log2(M))
//   W  sample width of x and y
//
// Ports
//   clk      single clock, rising-edge active
//   rst      synchronous active-high reset; takes priority over en
//   en       sample strobe; x is accepted on a rising edge with en=1
//   x        signed W-bit input sample
//   y        signed W-bit decimated output, held between dumps
//   y_valid  one-cycle pulse following each dump edge
// ---------------------------------------------------------------------------
module decimador_qmn #(
    parameter int M = 4,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y,
    output logic                y_valid
);

    localparam int K     = $clog2(M);
    localparam int ACC_W = W + K;

    // K guard bits hold the sum of M full-scale samples. The rounding
    // offset (M/2) added to the extreme positive sum still fits, because
    // M * (2^(W-1) - 1) + M/2 < 2^(W+K-1).
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(M / 2);
    localparam logic        [K-1:0]     CNT_LAST   = {K{1'b1}};

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [K-1:0]     cnt_q, cnt_d;
    logic signed [W-1:0]     y_q, y_d;
    logic                    y_valid_q, y_valid_d;

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_rnd;

    assign x_ext   = {{K{x[W-1]}}, x};
    assign sum     = acc_q + x_ext;
    assign sum_rnd = sum + ROUND_HALF;

    // NOTE: combinational next-state logic uses blocking assignments and
    // starts from a default for every output, so no path can hold a value
    // and infer a latch; the registers below use non-blocking assignments.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_valid_d = 1'b0;

        if (en) begin
            if (cnt_q == CNT_LAST) begin
                // Dump: the arithmetic shift by K divides by M. The low W
                // bits of the shifted value are the whole result, since the
                // mean of W-bit samples always fits in W bits.
                y_d       = W'(sum_rnd >>> K);
                y_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_decimador_qmn.sv
// ---------------------------------------------------------------------------
// tb_decimador_qmn
//
// Self-checking bench for decimador_qmn with M=4, W=16. A table of
// per-cycle records {rst, en, x, expected y, expected y_valid} is applied one
// clock at a time, and the outputs are compared 1 ns after each rising edge.
// Two hand-written sequences then exercise back-to-back pulse spacing and a
// reset that arrives together with the M-th sample.
// ---------------------------------------------------------------------------
module tb_decimador_qmn;

    localparam int M = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b0;
    logic signed [W-1:0] x   = '0;
    logic signed [W-1:0] y;
    logic                y_valid;

    int n_pass  = 0;
    int n_total = 0;

    decimador_qmn #(.M(M), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .x       (x),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                rst;
        logic                en;
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic                v;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input int xi,
                                input int yi, input logic vi);
        vec_t t;
        t.rst = r;
        t.en  = e;
        t.x   = W'(xi);
        t.y   = W'(yi);
        t.v   = vi;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one cycle's inputs, clock once, and land 1 ns past the edge.
    task automatic step(input logic r, input logic e, input int xi);
        rst = r;
        en  = e;
        x   = W'(xi);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int last_pulse;

        // Reset with a sample presented: sample is discarded, outputs zero.
        add(1, 1, 123, 0, 0);
        // Steady 100s: single pulse on the 4th edge, then low while idle.
        add(0, 1, 100, 0, 0);
        add(0, 1, 100, 0, 0);
        add(0, 1, 100, 0, 0);
        add(0, 1, 100, 100, 1);
        add(0, 0, 555, 100, 0);
        // 2.5 rounds up to 3; -2.5 rounds toward +infinity to -2.
        add(0, 1, 1, 100, 0);
        add(0, 1, 2, 100, 0);
        add(0, 1, 3, 100, 0);
        add(0, 1, 4, 3, 1);
        add(0, 1, -1, 3, 0);
        add(0, 1, -2, 3, 0);
        add(0, 1, -3, 3, 0);
        add(0, 1, -4, -2, 1);
        // Full-scale positive and negative: no wrap to the opposite sign.
        add(0, 1, 32767, -2, 0);
        add(0, 1, 32767, -2, 0);
        add(0, 1, 32767, -2, 0);
        add(0, 1, 32767, 32767, 1);
        add(0, 1, -32768, 32767, 0);
        add(0, 1, -32768, 32767, 0);
        add(0, 1, -32768, 32767, 0);
        add(0, 1, -32768, -32768, 1);
        // en gap inside a group: the x=999 values must be ignored.
        add(0, 1, 10, -32768, 0);
        add(0, 1, 20, -32768, 0);
        add(0, 0, 999, -32768, 0);
        add(0, 0, 999, -32768, 0);
        add(0, 0, 999, -32768, 0);
        add(0, 1, 30, -32768, 0);
        add(0, 1, 40, 25, 1);
        // Reset mid-group discards the partial sum.
        add(0, 1, 500, 25, 0);
        add(0, 1, 500, 25, 0);
        add(1, 0, 0, 0, 0);
        add(0, 1, 8, 0, 0);
        add(0, 1, 8, 0, 0);
        add(0, 1, 8, 0, 0);
        add(0, 1, 8, 8, 1);
        // Ramp 0..11 back-to-back: means 1.5, 5.5, 9.5 round to 2, 6, 10.
        add(0, 1, 0, 8, 0);
        add(0, 1, 1, 8, 0);
        add(0, 1, 2, 8, 0);
        add(0, 1, 3, 2, 1);
        add(0, 1, 4, 2, 0);
        add(0, 1, 5, 2, 0);
        add(0, 1, 6, 2, 0);
        add(0, 1, 7, 6, 1);
        add(0, 1, 8, 6, 0);
        add(0, 1, 9, 6, 0);
        add(0, 1, 10, 6, 0);
        add(0, 1, 11, 10, 1);
        // Small-magnitude rounding: 0.5 -> 1, -0.75 -> -1, -0.5 -> 0.
        add(0, 1, 2, 10, 0);
        add(0, 1, 0, 10, 0);
        add(0, 1, 0, 10, 0);
        add(0, 1, 0, 1, 1);
        add(0, 1, -3, 1, 0);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, -1, 1);
        add(0, 1, -2, -1, 0);
        add(0, 1, 0, -1, 0);
        add(0, 1, 0, -1, 0);
        add(0, 1, 0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, int'(vecs[i].x));
            check($sformatf("vec%0d y", i), int'(y), int'(vecs[i].y));
            check($sformatf("vec%0d y_valid", i), int'(y_valid), int'(vecs[i].v));
        end

        // Back-to-back: eight samples of -7 give two pulses 4 cycles apart,
        // each with y = floor(-6.5) = -7.
        pulses      = 0;
        first_pulse = -1;
        last_pulse  = -1;
        for (int i = 0; i < 2 * M; i++) begin
            step(0, 1, -7);
            if (y_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                last_pulse = i;
                check($sformatf("b2b y at cycle %0d", i), int'(y), -7);
            end
        end
        check("b2b pulse count", pulses, 2);
        check("b2b first pulse cycle", first_pulse, M - 1);
        check("b2b pulse spacing", last_pulse - first_pulse, M);

        // Reset coinciding with what would be the dumping sample: no pulse,
        // and the next group of four starts cleanly.
        step(0, 1, 1000);
        step(0, 1, 1000);
        step(0, 1, 1000);
        step(1, 1, 1000);
        check("rst+dump y", int'(y), 0);
        check("rst+dump y_valid", int'(y_valid), 0);
        pulses = 0;
        for (int i = 0; i < M; i++) begin
            step(0, 1, 4);
            if (y_valid) pulses++;
        end
        check("post-rst group y", int'(y), 4);
        check("post-rst group pulses", pulses, 1);
        step(0, 0, 0);
        check("post-rst idle y_valid", int'(y_valid), 0);
        check("post-rst idle y hold", int'(y), 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
